// File: rtl/game_pkg.sv
// Shared definitions for the arithmetic game: switch count, operator bit
// positions and the input-conditioner press-lock state encoding.
package game_pkg;

  localparam int NUM_SWITCHES = 4;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } cond_state_e;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic more_than_one(input logic [NUM_SWITCHES-1:0] v);
    return (v & (v - NUM_SWITCHES'(1))) != {NUM_SWITCHES{1'b0}};
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input channel: 2-flop synchroniser followed by a saturating-count
// debouncer that only flips its stable level after a sustained difference.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Synchroniser, counter and stable level registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any return to the stable level restarts the count, so glitches never latch
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q == stable_q) begin
      stable_d = stable_q;
      cnt_d    = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      stable_d = stable_q;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces the answer switches and start button and converts them into
// single-cycle events, with a press-lock FSM allowing one answer per press.
module input_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SWITCHES-1:0] switch_raw,
  input  logic                    start_raw,
  output logic [NUM_SWITCHES-1:0] switch_stable,
  output logic                    start_stable,
  output logic [NUM_SWITCHES-1:0] switch_pulse,
  output logic                    start_pulse,
  output logic                    multi_press,
  output logic                    locked
);

  cond_state_e             state_q;
  cond_state_e             state_d;
  logic [NUM_SWITCHES-1:0] switch_stable_q;
  logic                    start_stable_q;
  logic [NUM_SWITCHES-1:0] rise_s;
  logic [NUM_SWITCHES-1:0] switch_pulse_d;
  logic [NUM_SWITCHES-1:0] switch_pulse_q;
  logic                    multi_press_d;
  logic                    multi_press_q;
  logic                    start_pulse_q;

  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (switch_raw[i]),
      .stable_o (switch_stable[i])
    );
  end

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (start_raw),
    .stable_o (start_stable)
  );

  assign rise_s = switch_stable & ~switch_stable_q;

  // FSM state, edge-detect delay and pulse output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      switch_stable_q <= '0;
      start_stable_q  <= 1'b0;
      switch_pulse_q  <= '0;
      multi_press_q   <= 1'b0;
      start_pulse_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      switch_stable_q <= switch_stable;
      start_stable_q  <= start_stable;
      switch_pulse_q  <= switch_pulse_d;
      multi_press_q   <= multi_press_d;
      start_pulse_q   <= start_stable & ~start_stable_q;
    end
  end

  // Lock on any press; unlock only once every switch is released
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise_s != '0) state_d = LOCKED;
        else              state_d = IDLE;
      end
      LOCKED: begin
        if (switch_stable == '0) state_d = IDLE;
        else                     state_d = LOCKED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulse decode: a single rise is an answer, simultaneous rises are flagged
  always_comb begin
    switch_pulse_d = '0;
    multi_press_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (more_than_one(rise_s)) begin
          multi_press_d = 1'b1;
        end else begin
          switch_pulse_d = rise_s;
        end
      end
      LOCKED: begin
        switch_pulse_d = '0;
        multi_press_d  = 1'b0;
      end
      default: begin
        switch_pulse_d = '0;
        multi_press_d  = 1'b0;
      end
    endcase
  end

  assign switch_pulse = switch_pulse_q;
  assign multi_press  = multi_press_q;
  assign start_pulse  = start_pulse_q;
  assign locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES = 4; expected
// pulse events are queued by the stimulus and matched by a separate monitor.
module tb_input_conditioner;

  localparam int DB  = 4;
  localparam int LAT = DB + 3;   // input applied at a negedge -> pulse seen LAT negedges later

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] switch_raw = 4'b0000;
  logic       start_raw = 1'b0;
  logic [3:0] switch_stable;
  logic       start_stable;
  logic [3:0] switch_pulse;
  logic       start_pulse;
  logic       multi_press;
  logic       locked;

  input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk           (clk),
    .reset         (reset),
    .switch_raw    (switch_raw),
    .start_raw     (start_raw),
    .switch_stable (switch_stable),
    .start_stable  (start_stable),
    .switch_pulse  (switch_pulse),
    .start_pulse   (start_pulse),
    .multi_press   (multi_press),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] sw;
    logic       st;
    logic       mp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   c0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic void push(input int c, input logic [3:0] sw, input logic st, input logic mp);
    exp_t e;
    e.cyc = c;
    e.sw  = sw;
    e.st  = st;
    e.mp  = mp;
    exp_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every observed pulse must match the next queued expectation
  always @(negedge clk) begin
    if (switch_pulse != 4'b0000 || start_pulse || multi_press) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({switch_pulse, start_pulse, multi_press}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("switch_pulse", 32'(switch_pulse), 32'(mon_e.sw));
        check("start_pulse", 32'(start_pulse), 32'(mon_e.st));
        check("multi_press", 32'(multi_press), 32'(mon_e.mp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_switch_stable", 32'(switch_stable), 32'd0);
    check("rst_start_stable", 32'(start_stable), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    reset = 1'b1;
    tick(3);

    // Clean press and release timing
    c0 = cyc; switch_raw = 4'b0100; push(c0 + LAT, 4'b0100, 1'b0, 1'b0);
    wait_cyc(c0 + 5); check("clean_stable_early", 32'(switch_stable), 32'd0);
    wait_cyc(c0 + 6); check("clean_stable", 32'(switch_stable), 32'h4);
    check("clean_locked_early", 32'(locked), 32'd0);
    wait_cyc(c0 + 7); check("clean_locked", 32'(locked), 32'd1);
    tick(3);
    c0 = cyc; switch_raw = 4'b0000;
    wait_cyc(c0 + 5); check("release_stable_early", 32'(switch_stable), 32'h4);
    wait_cyc(c0 + 6); check("release_stable", 32'(switch_stable), 32'd0);
    check("release_locked_hold", 32'(locked), 32'd1);
    wait_cyc(c0 + 7); check("release_unlock", 32'(locked), 32'd0);
    tick(2);

    // Bounce on bit0 before settling high
    switch_raw = 4'b0001; tick(1);
    switch_raw = 4'b0000; tick(1);
    switch_raw = 4'b0001; tick(1);
    switch_raw = 4'b0000; tick(1);
    c0 = cyc; switch_raw = 4'b0001; push(c0 + LAT, 4'b0001, 1'b0, 1'b0);
    wait_cyc(c0 + 12);
    c0 = cyc; switch_raw = 4'b0000;
    wait_cyc(c0 + 8); check("bounce_unlock", 32'(locked), 32'd0);

    // Simultaneous multi-press
    c0 = cyc; switch_raw = 4'b0011; push(c0 + LAT, 4'b0000, 1'b0, 1'b1);
    wait_cyc(c0 + 8); check("multi_locked", 32'(locked), 32'd1);
    c0 = cyc; switch_raw = 4'b0000;
    wait_cyc(c0 + 8); check("multi_unlock", 32'(locked), 32'd0);

    // Staggered press: second switch while first is held is ignored
    c0 = cyc; switch_raw = 4'b0001; push(c0 + LAT, 4'b0001, 1'b0, 1'b0);
    wait_cyc(c0 + 10);
    c0 = cyc; switch_raw = 4'b0011;
    wait_cyc(c0 + 9);
    check("stagger_stable", 32'(switch_stable), 32'h3);
    check("stagger_locked", 32'(locked), 32'd1);
    c0 = cyc; switch_raw = 4'b0000;
    wait_cyc(c0 + 8); check("stagger_unlock", 32'(locked), 32'd0);

    // Fresh press after full release
    c0 = cyc; switch_raw = 4'b1000; push(c0 + LAT, 4'b1000, 1'b0, 1'b0);
    wait_cyc(c0 + 10);
    c0 = cyc; switch_raw = 4'b0000;
    wait_cyc(c0 + 8);

    // Start coincident with an answer
    c0 = cyc; start_raw = 1'b1; switch_raw = 4'b0010; push(c0 + LAT, 4'b0010, 1'b1, 1'b0);
    wait_cyc(c0 + 10); check("start_stable_hi", 32'(start_stable), 32'd1);
    c0 = cyc; start_raw = 1'b0; switch_raw = 4'b0000;
    wait_cyc(c0 + 8);
    check("start_stable_lo", 32'(start_stable), 32'd0);
    check("start_unlock", 32'(locked), 32'd0);

    // Reset mid-count, switch held through release
    c0 = cyc; switch_raw = 4'b0100;
    wait_cyc(c0 + 3);
    reset = 1'b0; #1;
    check("midrst_stable", 32'(switch_stable), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    tick(2);
    c0 = cyc; reset = 1'b1; push(c0 + LAT, 4'b0100, 1'b0, 1'b0);
    wait_cyc(c0 + 10); check("held_thru_rst_locked", 32'(locked), 32'd1);

    // Reset mid-lock, switch released during reset: nothing further reported
    reset = 1'b0; #1;
    check("lockrst_locked", 32'(locked), 32'd0);
    check("lockrst_stable", 32'(switch_stable), 32'd0);
    switch_raw = 4'b0000;
    tick(2);
    reset = 1'b1;
    tick(12);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
